// File: rtl/mux_4x1.sv
// Parameterised 4-to-1 word multiplexer with combinational and registered outputs.
// Define MUX_4X1_HOLD_EN to add the `en` load enable for out_q.
module mux_4x1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MUX_4X1_HOLD_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] in_00,
  input  logic [WIDTH-1:0] in_01,
  input  logic [WIDTH-1:0] in_10,
  input  logic [WIDTH-1:0] in_11,
  input  logic [1:0]       slct,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_out_q;

  // An unknown select propagates X rather than silently choosing in_00.
  always_comb begin
    w_sel = 'x;
    case (slct)
      2'b00:   w_sel = in_00;
      2'b01:   w_sel = in_01;
      2'b10:   w_sel = in_10;
      2'b11:   w_sel = in_11;
      default: w_sel = 'x;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q <= '0;
`ifdef MUX_4X1_HOLD_EN
    end else if (en) begin
`else
    end else begin
`endif
      r_out_q <= w_sel;
    end
  end

  assign out   = w_sel;
  assign out_q = r_out_q;

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1 at WIDTH=4: vector table for the
// combinational path, directed sequences for latency, reset and hold enable.
module tb_mux_4x1;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
`ifdef MUX_4X1_HOLD_EN
  logic         en;
`endif
  logic [W-1:0] in_00, in_01, in_10, in_11;
  logic [1:0]   slct;
  logic [W-1:0] out, out_q;

  int n_checks = 0;
  int n_fail   = 0;

  mux_4x1 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MUX_4X1_HOLD_EN
    .en    (en),
`endif
    .in_00 (in_00),
    .in_01 (in_01),
    .in_10 (in_10),
    .in_11 (in_11),
    .slct  (slct),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   s;
    logic [W-1:0] a, b, c, d;
    logic [W-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    logic [1:0]   sx;
    logic [W-1:0] exp_x;

    vt[0] = '{2'd0, 4'd2,  4'd4,  4'd6,  4'd8,  4'b0010};
    vt[1] = '{2'd1, 4'd2,  4'd4,  4'd6,  4'd8,  4'b0100};
    vt[2] = '{2'd2, 4'd2,  4'd4,  4'd6,  4'd8,  4'b0110};
    vt[3] = '{2'd3, 4'd2,  4'd4,  4'd6,  4'd8,  4'b1000};
    vt[4] = '{2'd0, 4'hF,  4'h0,  4'h0,  4'h0,  4'hF};
    vt[5] = '{2'd3, 4'h0,  4'h0,  4'h0,  4'hF,  4'hF};
    vt[6] = '{2'd1, 4'hA,  4'h5,  4'hC,  4'h3,  4'h5};
    vt[7] = '{2'd2, 4'hA,  4'h5,  4'hC,  4'h3,  4'hC};

    rst_n = 1'b0;
`ifdef MUX_4X1_HOLD_EN
    en    = 1'b1;
`endif
    in_00 = 4'd2; in_01 = 4'd4; in_10 = 4'd6; in_11 = 4'd8;
    slct  = 2'd0;
    #2;
    chk("reset_out_q", out_q, 4'b0000);

    // Combinational sweep with out_q held in reset
    for (int i = 0; i < 8; i++) begin
      in_00 = vt[i].a; in_01 = vt[i].b; in_10 = vt[i].c; in_11 = vt[i].d;
      slct  = vt[i].s;
      #1;
      chk($sformatf("comb_vec%0d", i), out, vt[i].exp);
    end
    edge_sample();
    chk("reset_hold_over_edge", out_q, 4'b0000);

    // Registered latency
    in_00 = 4'd2; in_01 = 4'd4; in_10 = 4'd6; in_11 = 4'd8;
    slct  = 2'd0;
    #2;
    rst_n = 1'b1;
    chk("pre_first_edge", out_q, 4'b0000);
    edge_sample(); chk("lat_s0", out_q, 4'b0010);
    slct = 2'd1; #1; chk("lat_s1_before_edge", out_q, 4'b0010);
    edge_sample(); chk("lat_s1", out_q, 4'b0100);
    slct = 2'd2;
    edge_sample(); chk("lat_s2", out_q, 4'b0110);
    slct = 2'd3;
    edge_sample(); chk("lat_s3", out_q, 4'b1000);

    // Async reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_q", out_q, 4'b0000);
    chk("async_rst_out", out, 4'b1000);
    edge_sample();
    chk("rst_low_edge_out_q", out_q, 4'b0000);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_release_no_edge", out_q, 4'b0000);
    edge_sample();
    chk("reload_after_rst", out_q, 4'b1000);

    // Data change under fixed select
    slct = 2'd2;
    edge_sample();
    chk("sel2_q", out_q, 4'b0110);
    in_10 = 4'd9;
    #1;
    chk("data_chg_out", out, 4'b1001);
    chk("data_chg_q_before", out_q, 4'b0110);
    edge_sample();
    chk("data_chg_q", out_q, 4'b1001);

    // Simultaneous select and data change
    slct = 2'd1; in_01 = 4'd7;
    #1;
    chk("simul_out", out, 4'd7);
    edge_sample();
    chk("simul_q", out_q, 4'd7);

    // Unknown select; a two-state simulator may resolve the literal to a known code
    slct = 2'bx0;
    #1;
    sx = slct;
    if ($isunknown(sx)) exp_x = 'x;
    else case (sx)
      2'd0: exp_x = in_00;
      2'd1: exp_x = in_01;
      2'd2: exp_x = in_10;
      default: exp_x = in_11;
    endcase
    chk("x_select_out", out, exp_x);
    slct = 2'd0;
    #1;
    chk("x_recover_out", out, 4'b0010);

`ifdef MUX_4X1_HOLD_EN
    en = 1'b1;
    edge_sample();
    chk("hold_load", out_q, 4'b0010);
    en = 1'b0;
    slct = 2'd3;
    #1;
    chk("hold_out", out, 4'b1000);
    edge_sample();
    chk("hold_q", out_q, 4'b0010);
    edge_sample();
    chk("hold_q2", out_q, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("hold_rst_q", out_q, 4'b0000);
    rst_n = 1'b1;
    en = 1'b1;
    edge_sample();
    chk("hold_en_q", out_q, 4'b1000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_4x1.md
Name: mux_4x1

Overview:
- Parameterised 4-to-1 word multiplexer used throughout the datapath for operand, forwarding and write-back source selection.
- Provides two outputs:
  - a zero-latency combinational output, `out`;
  - a registered copy, `out_q`, for pipeline-stage boundaries.
- Instantiations connect ports by name.

Parameters:
- WIDTH, default 32: bit width of every data input and of both outputs. Any value ≥ 1 is legal.

Ports:
- clk  input  1  system clock; `out_q` updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears `out_q`.
- in_00  input  WIDTH  data selected when slct = 2'b00.
- in_01  input  WIDTH  data selected when slct = 2'b01.
- in_10  input  WIDTH  data selected when slct = 2'b10.
- in_11  input  WIDTH  data selected when slct = 2'b11.
- slct  input  2  select code.
- out  output  WIDTH  combinational selected word.
- out_q  output  WIDTH  registered selected word.
- en  input  1  load enable for `out_q`. Present only when MUX_4X1_HOLD_EN is defined.

Behaviour:
- Combinational path:
  - out = in_00 / in_01 / in_10 / in_11 for slct = 0 / 1 / 2 / 3.
  - Purely combinational, zero latency; out follows any input or slct change within the same delta cycle.
  - No latches inferred; all four codes are decoded explicitly.
  - If slct contains X or Z, out = all-X in simulation. No silent default to in_00.
- Registered path:
  - On posedge clk with rst_n = 1, out_q <= the current value of out.
  - Latency is exactly 1 cycle from inputs/slct to out_q.
- Reset:
  - rst_n = 0 forces out_q = 0 immediately, with no dependence on clk.
  - out_q holds 0 while rst_n stays low.
  - The first load occurs on the first rising edge after rst_n deasserts.
  - out is unaffected by reset and keeps reflecting the selected input throughout.
- Reset asserted mid-operation: out_q clears asynchronously. The pending captured value is discarded, not delayed.
- Width rules: no truncation or extension; every data port and both outputs are exactly WIDTH bits.
- Simultaneous events: if slct and the selected data both change in the same cycle, out reflects the new pair. out_q captures the pair's value at the clock edge.
- No internal state other than the out_q register.

Optional Feature:
- Macro: MUX_4X1_HOLD_EN.
- Defined:
  - Input port `en` is added.
  - out_q loads `out` on posedge clk only when en = 1; when en = 0, out_q holds its value.
  - Reset still clears out_q regardless of en.
  - The combinational out is unaffected by en.
- Undefined:
  - No `en` port.
  - out_q loads every rising clock edge.

Test Plan (WIDTH=4, in_00=2, in_01=4, in_10=6, in_11=8):
1. Combinational sweep:
   - slct = 0, 1, 2, 3 with no clock activity.
   - out = 0010, 0100, 0110, 1000 respectively, each checked 1 time unit after the slct change.
2. Registered latency:
   - rst_n released; slct stepped 0→1→2→3 on successive edges.
   - out_q lags out by exactly one edge: 0010, 0100, 0110, 1000.
3. Async reset mid-run:
   - slct = 3, out_q = 1000; pull rst_n low between edges.
   - out_q = 0000 immediately; out stays 1000; out_q reloads 1000 on the first edge after rst_n goes high.
4. Data change under fixed select:
   - slct = 2; change in_10 6→9.
   - out = 1001 immediately; out_q = 1001 after the next edge.
5. X select:
   - slct = 2'bx0.
   - out = xxxx; no latch or hold of the previous value.
6. MUX_4X1_HOLD_EN defined:
   - en = 0, slct 0→3.
   - out = 1000 while out_q holds 0010.
   - Set en = 1; out_q = 1000 after the next edge.
